scb_sched: RTL and testbench
============================

SCB_SCHED -- requirements
Module: scb_sched

Interface
REQ-001 Parameters SHALL be: N_CELL, default 8, number of entries; W_ident, default 4, entry index width; W_pip, default 1, pipe tag width; W_PA_rx, default 5, register address width; W_state, default 7, latency counter width.
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- CFI_PC_clear  in  1  control-flow flush, synchronous
- iss_valid  in  1  issue request
- iss_ready  out  1  issue accepted when iss_valid & iss_ready
- iss_pip  in  W_pip  pipe tag of issuing op
- iss_rd_a  in  W_PA_rx  destination register
- iss_lat  in  W_state  cycles until result ready
- wb_valid  out  1  granted entry has a ready result
- wb_ready  in  1  writeback port accepts grant
- wb_pip  out  W_pip  granted entry's pipe tag
- wb_rd_a  out  W_PA_rx  granted entry's destination
- wb_ident  out  W_ident  granted entry index
- hz_rs1_a, hz_rs2_a  in  W_PA_rx  source registers to check
- hz_rs1_busy, hz_rs2_busy  out  1  source has pending writer
- full, empty  out  1  occupancy flags
- occ  out  W_ident  in-use entry count, 0..N_CELL

Function
REQ-003 Each entry SHALL hold INUSED, PIP, RD, and STATE (W_state) registers.
REQ-004 Issue SHALL be accepted when iss_valid & iss_ready, loading the lowest-index free entry with INUSED=1, PIP=iss_pip, RD=iss_rd_a, STATE=iss_lat at the next edge.
REQ-005 iss_ready SHALL be the combination of all of: !full; !CFI_PC_clear; and no WAW conflict, where a WAW conflict is iss_rd_a != 0 matching RD of any in-use entry, evaluated on registered state.
REQ-006 An entry freed in cycle t SHALL NOT count as free for issue in cycle t; it becomes allocatable from t+1.
REQ-007 Each in-use entry with STATE != 0 SHALL decrement STATE by 1 per cycle; STATE SHALL hold at 0 until the entry is granted.
REQ-008 Latency: an op issued in cycle t with iss_lat = L SHALL become a writeback candidate in cycle t+1+L (L=0 gives a candidate at t+1).
REQ-009 Candidates SHALL be entries with INUSED & STATE==0; arbitration SHALL be round-robin from pointer RR_PTR, granting the first candidate at index >= RR_PTR, wrapping modulo N_CELL.
REQ-010 wb_valid SHALL be 1 when any candidate exists and CFI_PC_clear is 0; wb_pip, wb_rd_a, and wb_ident SHALL reflect the granted entry, and be 0 when wb_valid is 0.
REQ-011 On wb_valid & wb_ready, the granted entry SHALL clear INUSED and RR_PTR SHALL become (wb_ident+1) mod N_CELL; when wb_ready is 0, the grant SHALL be held stable if no new entry at or after RR_PTR precedes it.
REQ-012 hz_rsN_busy SHALL be 1 iff hz_rsN_a != 0 and some in-use entry has RD == hz_rsN_a; the output is combinational.
REQ-013 occ SHALL equal the number of in-use entries; full = (occ == N_CELL); empty = (occ == 0).
REQ-014 Simultaneous issue and writeback in one cycle SHALL both take effect; occ stays unchanged.
REQ-015 CFI_PC_clear SHALL clear every INUSED at the next edge, block issue, and suppress wb_valid that cycle; RR_PTR SHALL be unchanged by CFI_PC_clear.
REQ-016 Register 0 SHALL never create a hazard or WAW conflict, but is still tracked for writeback.

Reset
REQ-017 On rst, all INUSED and RR_PTR SHALL be 0, and rst SHALL override CFI_PC_clear, issue, and writeback.
REQ-018 After rst: iss_ready=1 (given iss_valid), wb_valid=0, wb_* outputs=0, hz_*_busy=0, full=0, empty=1, occ=0.
REQ-019 rst asserted mid-operation SHALL drop all pending entries with no writeback granted in that cycle.

Verification
REQ-020 Issue rd=5, lat=3 in cycle 0 with wb_ready=1 -> wb_valid=1 only in cycle 4, wb_rd_a=5, wb_ident=0; empty=1 from cycle 5.
REQ-021 Issue 8 ops with distinct rd 1..8, lat=20 -> full=1, occ=8, iss_ready=0; a 9th request is stalled until the first writeback, and reuses the freed index one cycle later.
REQ-022 Issue rd=7 while an entry with rd=7 is pending -> iss_ready=0, hz_rs1_busy=1 for hz_rs1_a=7; issue rd=0 twice -> both accepted.
REQ-023 Three entries at indices 0, 1, 2 all reach STATE 0 in the same cycle with wb_ready=1 -> grants in order 0, 1, 2 on consecutive cycles; with wb_ready=0 for 2 cycles, wb_ident holds at 0.
REQ-024 CFI_PC_clear with occ=4 and a candidate present -> wb_valid=0 that cycle, occ=0 and empty=1 next cycle, RR_PTR unchanged.
REQ-025 Issue and writeback in the same cycle at occ=3 -> occ=3 next cycle.

Source files
------------

// File: rtl/scb_sched.sv
// Writeback scoreboard: tracks in-flight ops by destination register, counts down
// their latency, and grants completed results to the writeback port round-robin.
module scb_sched #(
    parameter int unsigned N_CELL  = 8,
    parameter int unsigned W_ident = 4,
    parameter int unsigned W_pip   = 1,
    parameter int unsigned W_PA_rx = 5,
    parameter int unsigned W_state = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               CFI_PC_clear,
    input  logic               iss_valid,
    output logic               iss_ready,
    input  logic [W_pip-1:0]   iss_pip,
    input  logic [W_PA_rx-1:0] iss_rd_a,
    input  logic [W_state-1:0] iss_lat,
    output logic               wb_valid,
    input  logic               wb_ready,
    output logic [W_pip-1:0]   wb_pip,
    output logic [W_PA_rx-1:0] wb_rd_a,
    output logic [W_ident-1:0] wb_ident,
    input  logic [W_PA_rx-1:0] hz_rs1_a,
    input  logic [W_PA_rx-1:0] hz_rs2_a,
    output logic               hz_rs1_busy,
    output logic               hz_rs2_busy,
    output logic               full,
    output logic               empty,
    output logic [W_ident-1:0] occ
);
    localparam int unsigned      IDX_W    = (N_CELL > 1) ? $clog2(N_CELL) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CELL - 1);

    typedef struct packed {
        logic [W_pip-1:0]   pip;
        logic [W_PA_rx-1:0] rd;
        logic [W_state-1:0] state;
    } entry_t;

    logic [N_CELL-1:0]  inuse_q, inuse_d;
    entry_t             ent_q [N_CELL];
    entry_t             ent_d [N_CELL];
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [W_ident-1:0] occ_q, occ_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;

    logic [N_CELL-1:0]  cand_c;
    logic               cand_any_c;
    logic [IDX_W-1:0]   gnt_idx_c;
    entry_t             gnt_ent_c;
    logic [IDX_W-1:0]   free_idx_c;
    logic               free_found_c;
    logic               waw_c;
    logic               iss_fire_c;
    logic               wb_fire_c;

    // Round-robin pick: first candidate at or above the pointer, else the lowest one below it.
    always_comb begin
        cand_c     = '0;
        cand_any_c = 1'b0;
        gnt_idx_c  = '0;
        for (int i = 0; i < N_CELL; i++) begin
            cand_c[i] = inuse_q[i] && (ent_q[i].state == '0);
        end
        for (int i = 0; i < N_CELL; i++) begin
            if (!cand_any_c && cand_c[i] && (IDX_W'(i) >= rr_ptr_q)) begin
                cand_any_c = 1'b1;
                gnt_idx_c  = IDX_W'(i);
            end
        end
        for (int i = 0; i < N_CELL; i++) begin
            if (!cand_any_c && cand_c[i]) begin
                cand_any_c = 1'b1;
                gnt_idx_c  = IDX_W'(i);
            end
        end
    end

    always_comb begin
        gnt_ent_c = '0;
        for (int i = 0; i < N_CELL; i++) begin
            if (IDX_W'(i) == gnt_idx_c) begin
                gnt_ent_c = ent_q[i];
            end
        end
    end

    // Lowest free slot, from registered occupancy only.
    always_comb begin
        free_found_c = 1'b0;
        free_idx_c   = '0;
        for (int i = 0; i < N_CELL; i++) begin
            if (!free_found_c && !inuse_q[i]) begin
                free_found_c = 1'b1;
                free_idx_c   = IDX_W'(i);
            end
        end
    end

    // Register 0 never conflicts.
    always_comb begin
        waw_c       = 1'b0;
        hz_rs1_busy = 1'b0;
        hz_rs2_busy = 1'b0;
        for (int i = 0; i < N_CELL; i++) begin
            if (inuse_q[i]) begin
                if ((iss_rd_a != '0) && (ent_q[i].rd == iss_rd_a)) begin
                    waw_c = 1'b1;
                end
                if ((hz_rs1_a != '0) && (ent_q[i].rd == hz_rs1_a)) begin
                    hz_rs1_busy = 1'b1;
                end
                if ((hz_rs2_a != '0) && (ent_q[i].rd == hz_rs2_a)) begin
                    hz_rs2_busy = 1'b1;
                end
            end
        end
    end

    assign iss_ready  = !full_q && !CFI_PC_clear && !waw_c;
    assign iss_fire_c = iss_valid && iss_ready;
    assign wb_valid   = cand_any_c && !CFI_PC_clear && !rst;
    assign wb_fire_c  = wb_valid && wb_ready;
    assign wb_pip     = wb_valid ? gnt_ent_c.pip : '0;
    assign wb_rd_a    = wb_valid ? gnt_ent_c.rd : '0;
    assign wb_ident   = wb_valid ? W_ident'(gnt_idx_c) : '0;
    assign occ        = occ_q;
    assign full       = full_q;
    assign empty      = empty_q;

    // Entry table next state: countdown, retire, allocate, then flush wins.
    always_comb begin
        inuse_d  = inuse_q;
        rr_ptr_d = rr_ptr_q;
        for (int i = 0; i < N_CELL; i++) begin
            ent_d[i] = ent_q[i];
            if (inuse_q[i] && (ent_q[i].state != '0)) begin
                ent_d[i].state = ent_q[i].state - W_state'(1);
            end
            if (wb_fire_c && (IDX_W'(i) == gnt_idx_c)) begin
                inuse_d[i] = 1'b0;
            end
            if (iss_fire_c && (IDX_W'(i) == free_idx_c)) begin
                inuse_d[i]     = 1'b1;
                ent_d[i].pip   = iss_pip;
                ent_d[i].rd    = iss_rd_a;
                ent_d[i].state = iss_lat;
            end
        end
        if (wb_fire_c) begin
            rr_ptr_d = (gnt_idx_c == LAST_IDX) ? '0 : gnt_idx_c + IDX_W'(1);
        end
        if (CFI_PC_clear) begin
            inuse_d = '0;
        end
    end

    always_comb begin
        occ_d = occ_q;
        if (CFI_PC_clear) begin
            occ_d = '0;
        end else if (iss_fire_c && !wb_fire_c) begin
            occ_d = occ_q + W_ident'(1);
        end else if (!iss_fire_c && wb_fire_c) begin
            occ_d = occ_q - W_ident'(1);
        end
        full_d  = (occ_d == W_ident'(N_CELL));
        empty_d = (occ_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inuse_q  <= '0;
            rr_ptr_q <= '0;
            occ_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            for (int i = 0; i < N_CELL; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            inuse_q  <= inuse_d;
            rr_ptr_q <= rr_ptr_d;
            occ_q    <= occ_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            for (int i = 0; i < N_CELL; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

endmodule

// File: tb/tb_scb_sched.sv
// Randomized bench for scb_sched against a timestamp-based scoreboard model.
module tb_scb_sched;
    localparam int unsigned N_CELL  = 8;
    localparam int unsigned W_ident = 4;
    localparam int unsigned W_pip   = 1;
    localparam int unsigned W_PA_rx = 5;
    localparam int unsigned W_state = 7;

    logic               clk = 1'b0;
    logic               rst;
    logic               CFI_PC_clear;
    logic               iss_valid;
    logic               iss_ready;
    logic [W_pip-1:0]   iss_pip;
    logic [W_PA_rx-1:0] iss_rd_a;
    logic [W_state-1:0] iss_lat;
    logic               wb_valid;
    logic               wb_ready;
    logic [W_pip-1:0]   wb_pip;
    logic [W_PA_rx-1:0] wb_rd_a;
    logic [W_ident-1:0] wb_ident;
    logic [W_PA_rx-1:0] hz_rs1_a;
    logic [W_PA_rx-1:0] hz_rs2_a;
    logic               hz_rs1_busy;
    logic               hz_rs2_busy;
    logic               full;
    logic               empty;
    logic [W_ident-1:0] occ;

    always #5 clk = ~clk;

    scb_sched #(
        .N_CELL(N_CELL), .W_ident(W_ident), .W_pip(W_pip), .W_PA_rx(W_PA_rx), .W_state(W_state)
    ) dut (
        .clk(clk), .rst(rst), .CFI_PC_clear(CFI_PC_clear),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_pip(iss_pip),
        .iss_rd_a(iss_rd_a), .iss_lat(iss_lat),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pip(wb_pip),
        .wb_rd_a(wb_rd_a), .wb_ident(wb_ident),
        .hz_rs1_a(hz_rs1_a), .hz_rs2_a(hz_rs2_a),
        .hz_rs1_busy(hz_rs1_busy), .hz_rs2_busy(hz_rs2_busy),
        .full(full), .empty(empty), .occ(occ)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: each slot remembers the absolute cycle at which its result is ready.
    bit m_used [N_CELL];
    int m_rd   [N_CELL];
    int m_pip  [N_CELL];
    int m_rdy  [N_CELL];
    int m_rr;

    task automatic chk(input string tag, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic step(input bit r, input bit c, input bit iv, input int pip, input int rd,
                        input int lat, input bit wr, input int h1, input int h2);
        int  occ_m, g, f, idx;
        bit  any, waw, b1, b2, e_wv, e_ir;
        rst          = r;
        CFI_PC_clear = c;
        iss_valid    = iv;
        iss_pip      = W_pip'(pip);
        iss_rd_a     = W_PA_rx'(rd);
        iss_lat      = W_state'(lat);
        wb_ready     = wr;
        hz_rs1_a     = W_PA_rx'(h1);
        hz_rs2_a     = W_PA_rx'(h2);
        #1;
        occ_m = 0; waw = 0; b1 = 0; b2 = 0; f = -1;
        for (int i = 0; i < N_CELL; i++) begin
            if (m_used[i]) begin
                occ_m++;
                if (rd != 0 && m_rd[i] == rd) waw = 1;
                if (h1 != 0 && m_rd[i] == h1) b1 = 1;
                if (h2 != 0 && m_rd[i] == h2) b2 = 1;
            end else if (f < 0) begin
                f = i;
            end
        end
        any = 0; g = 0;
        for (int k = 0; k < N_CELL; k++) begin
            idx = (m_rr + k) % N_CELL;
            if (!any && m_used[idx] && cyc >= m_rdy[idx]) begin
                any = 1;
                g   = idx;
            end
        end
        e_wv = any && !c && !r;
        e_ir = (occ_m < N_CELL) && !c && !waw;
        chk("wb_valid", int'(wb_valid), int'(e_wv));
        if (!r) begin
            chk("iss_ready", int'(iss_ready), int'(e_ir));
            chk("wb_pip",    int'(wb_pip),    e_wv ? m_pip[g] : 0);
            chk("wb_rd_a",   int'(wb_rd_a),   e_wv ? m_rd[g] : 0);
            chk("wb_ident",  int'(wb_ident),  e_wv ? g : 0);
            chk("hz_rs1",    int'(hz_rs1_busy), int'(b1));
            chk("hz_rs2",    int'(hz_rs2_busy), int'(b2));
            chk("occ",       int'(occ),   occ_m);
            chk("full",      int'(full),  int'(occ_m == N_CELL));
            chk("empty",     int'(empty), int'(occ_m == 0));
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < N_CELL; i++) m_used[i] = 0;
            m_rr = 0;
        end else if (c) begin
            for (int i = 0; i < N_CELL; i++) m_used[i] = 0;
        end else begin
            if (e_wv && wr) begin
                m_used[g] = 0;
                m_rr      = (g + 1) % N_CELL;
            end
            if (iv && e_ir) begin
                m_used[f] = 1;
                m_rd[f]   = rd;
                m_pip[f]  = pip;
                m_rdy[f]  = cyc + 1 + lat;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit wr);
        repeat (n) step(0, 0, 0, 0, 0, 0, wr, $urandom_range(0, 9), $urandom_range(0, 9));
    endtask

    initial begin
        int r_rst, r_clr, r_iv, r_pip, r_rd, r_lat, r_wr, r_h1, r_h2;
        rst = 1; CFI_PC_clear = 0; iss_valid = 0; iss_pip = '0; iss_rd_a = '0;
        iss_lat = '0; wb_ready = 0; hz_rs1_a = '0; hz_rs2_a = '0;
        m_rr = 0;
        for (int i = 0; i < N_CELL; i++) begin
            m_used[i] = 0; m_rd[i] = 0; m_pip[i] = 0; m_rdy[i] = 0;
        end
        @(negedge clk);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 3, 0, 1, 0, 0);

        // Single op, latency 3.
        step(0, 0, 1, 0, 5, 3, 1, 5, 5);
        idle(6, 1);

        // Fill all slots, then a ninth request waits for the first retirement.
        for (int k = 1; k <= 8; k++) step(0, 0, 1, k & 1, k, 20, 1, k, 0);
        repeat (25) step(0, 0, 1, 0, 9, 1, 1, 9, 1);
        idle(30, 1);

        // WAW stall and register-0 exemption.
        step(0, 0, 1, 1, 7, 10, 1, 7, 0);
        step(0, 0, 1, 0, 7, 2, 1, 7, 0);
        step(0, 0, 1, 0, 0, 1, 1, 0, 7);
        step(0, 0, 1, 1, 0, 1, 1, 7, 0);
        idle(15, 1);

        // Three results maturing together, stalled then drained.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 1, 5, 0, 1, 2);
        step(0, 0, 1, 1, 2, 4, 0, 2, 3);
        step(0, 0, 1, 0, 3, 3, 0, 3, 1);
        idle(5, 0);
        idle(5, 1);

        // Flush with a candidate pending.
        for (int k = 1; k <= 4; k++) step(0, 0, 1, 0, k, 0, 0, k, 0);
        step(0, 1, 1, 0, 6, 0, 1, 1, 2);
        step(0, 0, 0, 0, 0, 0, 1, 1, 2);
        for (int k = 1; k <= 3; k++) step(0, 0, 1, 1, k, 0, 0, 0, k);
        idle(2, 1);

        // Simultaneous issue and writeback.
        for (int k = 1; k <= 3; k++) step(0, 0, 1, 0, k + 3, 0, 0, k, 0);
        step(0, 0, 1, 1, 9, 5, 1, 9, 4);
        idle(12, 1);

        for (int n = 0; n < 4000; n++) begin
            r_rst = ($urandom_range(0, 199) == 0) ? 1 : 0;
            r_clr = ($urandom_range(0, 39) == 0) ? 1 : 0;
            r_iv  = ($urandom_range(0, 9) < 6) ? 1 : 0;
            r_pip = $urandom_range(0, 1);
            r_rd  = $urandom_range(0, 7);
            r_lat = ($urandom_range(0, 15) == 0) ? $urandom_range(10, 40) : $urandom_range(0, 6);
            r_wr  = ($urandom_range(0, 9) < 7) ? 1 : 0;
            r_h1  = $urandom_range(0, 7);
            r_h2  = $urandom_range(0, 7);
            step(r_rst[0], r_clr[0], r_iv[0], r_pip, r_rd, r_lat, r_wr[0], r_h1, r_h2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
